// File: rtl/board_placement_search_if.sv
// Candidate/result bus between the placement search and the downstream board simulator.
interface board_placement_search_if;
    logic [3:0]   sim_block;
    logic [3:0]   sim_col;
    logic [1:0]   sim_rotation;
    logic [199:0] sim_board;
    logic         sim_request;
    logic         sim_valid;
    logic [199:0] sim_next_board;
    logic [9:0]   sim_cleared_lines;
    logic         sim_ready;

    modport master (
        output sim_block, sim_col, sim_rotation, sim_board, sim_request,
        input  sim_valid, sim_next_board, sim_cleared_lines, sim_ready
    );

    modport slave (
        input  sim_block, sim_col, sim_rotation, sim_board, sim_request,
        output sim_valid, sim_next_board, sim_cleared_lines, sim_ready
    );
endinterface

// File: rtl/board_placement_search.sv
// Exhaustive placement search: walks every (rotation, column) of a piece through an
// external board simulator and keeps the best-scoring resulting board.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | sim_request high for the current candidate
// WAIT  | waiting for sim_ready, bounded by SIM_TIMEOUT
// SCORE | score captured result, update best, pick next candidate
// DONE  | search finished; done pulses on the following cycle
module board_placement_search #(
    parameter int CLEAR_WEIGHT  = 8,
    parameter int HEIGHT_WEIGHT = 1,
    parameter int SIM_TIMEOUT   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [3:0]                      cur_block,
    input  logic [199:0]                    cur_board,
    board_placement_search_if.master        sim,
    output logic                            busy,
    output logic                            done,
    output logic                            found,
    output logic [3:0]                      best_col,
    output logic [1:0]                      best_rotation,
    output logic [9:0]                      best_cleared,
    output logic [199:0]                    best_board
);
    localparam int WW = (SIM_TIMEOUT > 1) ? $clog2(SIM_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SCORE, DONE} state_t;

    state_t              state;
    logic [WW-1:0]       wait_cnt;
    logic                cap_valid;
    logic [9:0]          cap_cleared;
    logic [199:0]        cap_board;
    logic signed [15:0]  best_score;

    logic [1:0]          rot_max;
    logic                last_cand;
    logic [3:0]          nxt_col;
    logic [1:0]          nxt_rot;
    logic [4:0]          height;
    logic signed [15:0]  score;

    // The snapshot block lives in sim_block, so it also selects the rotation count.
    always_comb begin
        rot_max = 2'd1;
        case (sim.sim_block)
            4'd1:                rot_max = 2'd0;
            4'd2, 4'd5, 4'd6:    rot_max = 2'd3;
            default:             rot_max = 2'd1;
        endcase
        last_cand = (sim.sim_col == 4'd9) && (sim.sim_rotation == rot_max);
        nxt_col   = (sim.sim_col == 4'd9) ? 4'd0 : sim.sim_col + 4'd1;
        nxt_rot   = (sim.sim_col == 4'd9) ? sim.sim_rotation + 2'd1 : sim.sim_rotation;
    end

    // Scan bottom-up so the last hit is the topmost occupied row.
    always_comb begin
        height = 5'd0;
        for (int r = 19; r >= 0; r--) begin
            if (|cap_board[r*10 +: 10]) height = 5'(20 - r);
        end
        score = 16'(CLEAR_WEIGHT * int'(cap_cleared) - HEIGHT_WEIGHT * int'(height));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            cap_valid         <= 1'b0;
            cap_cleared       <= '0;
            cap_board         <= '0;
            best_score        <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            found             <= 1'b0;
            best_col          <= '0;
            best_rotation     <= '0;
            best_cleared      <= '0;
            best_board        <= '0;
            sim.sim_block     <= '0;
            sim.sim_col       <= '0;
            sim.sim_rotation  <= '0;
            sim.sim_board     <= '0;
            sim.sim_request   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sim.sim_block    <= cur_block;
                        sim.sim_board    <= cur_board;
                        sim.sim_col      <= 4'd0;
                        sim.sim_rotation <= 2'd0;
                        sim.sim_request  <= 1'b1;
                        found            <= 1'b0;
                        best_score       <= '0;
                        best_col         <= '0;
                        best_rotation    <= '0;
                        best_cleared     <= '0;
                        best_board       <= '0;
                        busy             <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    sim.sim_request <= 1'b0;
                    wait_cnt        <= WW'(SIM_TIMEOUT - 1);
                    state           <= WAIT;
                end
                WAIT: begin
                    if (sim.sim_ready) begin
                        cap_valid   <= sim.sim_valid;
                        cap_board   <= sim.sim_next_board;
                        cap_cleared <= sim.sim_cleared_lines;
                        state       <= SCORE;
                    end else if (wait_cnt == '0) begin
                        cap_valid <= 1'b0;
                        state     <= SCORE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                SCORE: begin
                    if (cap_valid && (!found || score > best_score)) begin
                        found         <= 1'b1;
                        best_score    <= score;
                        best_col      <= sim.sim_col;
                        best_rotation <= sim.sim_rotation;
                        best_cleared  <= cap_cleared;
                        best_board    <= cap_board;
                    end
                    if (last_cand) begin
                        state <= DONE;
                    end else begin
                        sim.sim_col      <= nxt_col;
                        sim.sim_rotation <= nxt_rot;
                        sim.sim_request  <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_placement_search.sv
// Scoreboard bench: stimulus queues expected requests/results, a monitor checks them.
module tb_board_placement_search;
    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   cur_block;
    logic [199:0] cur_board;
    logic         busy, done, found;
    logic [3:0]   best_col;
    logic [1:0]   best_rotation;
    logic [9:0]   best_cleared;
    logic [199:0] best_board;

    board_placement_search_if sim_bus();

    board_placement_search dut (
        .clk(clk), .rst(rst), .start(start), .cur_block(cur_block), .cur_board(cur_board),
        .sim(sim_bus), .busy(busy), .done(done), .found(found), .best_col(best_col),
        .best_rotation(best_rotation), .best_cleared(best_cleared), .best_board(best_board)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   blk;
        logic [3:0]   col;
        logic [1:0]   rot;
        logic [199:0] board;
    } req_t;

    typedef struct {
        logic         found;
        logic [3:0]   col;
        logic [1:0]   rot;
        logic [9:0]   cleared;
        logic [199:0] board;
        int           lat;
    } res_t;

    req_t exp_req[$];
    res_t exp_res[$];
    int   checks = 0, errors = 0;
    int   mode = 1;
    int   start_cyc = 0;
    bit   late_pulse = 1'b0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [199:0] tag_board(input int c, input int r);
        logic [199:0] b;
        b = '0;
        b[180] = 1'b1;
        b[190 +: 4] = 4'(c);
        b[194 +: 2] = 2'(r);
        return b;
    endfunction

    function automatic int resp_cleared(input int c, input int r);
        if (mode == 2) return (r == 2 && c == 5) ? 1 : 0;
        if (mode == 4) return (c == 3) ? 2 : ((c == 7) ? 1 : 0);
        return 0;
    endfunction

    function automatic logic [199:0] resp_board(input int c, input int r);
        if (mode == 7 && r == 1 && c == 9) return '0;
        return tag_board(c, r);
    endfunction

    function automatic bit withhold(input int c);
        return (mode == 4 && c == 3) || (mode == 5 && c == 1);
    endfunction

    // Board simulator stub: answers in the cycle after the request.
    initial begin
        bit pend = 1'b0;
        int pc = 0, pr = 0;
        sim_bus.sim_ready = 1'b0;
        sim_bus.sim_valid = 1'b0;
        sim_bus.sim_cleared_lines = '0;
        sim_bus.sim_next_board = '0;
        forever begin
            @(negedge clk);
            sim_bus.sim_ready = 1'b0;
            if (late_pulse) begin
                late_pulse = 1'b0;
                sim_bus.sim_ready = 1'b1;
                sim_bus.sim_valid = 1'b1;
                sim_bus.sim_cleared_lines = 10'd5;
                sim_bus.sim_next_board = tag_board(1, 0);
            end
            if (pend) begin
                pend = 1'b0;
                if (!withhold(pc)) begin
                    sim_bus.sim_ready = 1'b1;
                    sim_bus.sim_valid = (mode != 3);
                    sim_bus.sim_cleared_lines = 10'(resp_cleared(pc, pr));
                    sim_bus.sim_next_board = resp_board(pc, pr);
                end
            end
            if (sim_bus.sim_request) begin
                pend = 1'b1;
                pc = int'(sim_bus.sim_col);
                pr = int'(sim_bus.sim_rotation);
            end
        end
    end

    // Monitor: every request and every done pulse must match a queued expectation.
    initial begin
        req_t q;
        res_t r;
        forever begin
            @(negedge clk);
            if (sim_bus.sim_request) begin
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_request actual col=%0d rot=%0d required none",
                             sim_bus.sim_col, sim_bus.sim_rotation);
                end else begin
                    q = exp_req.pop_front();
                    chk("req_col", 200'(sim_bus.sim_col), 200'(q.col));
                    chk("req_rot", 200'(sim_bus.sim_rotation), 200'(q.rot));
                    chk("req_block", 200'(sim_bus.sim_block), 200'(q.blk));
                    chk("req_board", sim_bus.sim_board, q.board);
                end
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    r = exp_res.pop_front();
                    chk("found", 200'(found), 200'(r.found));
                    chk("best_col", 200'(best_col), 200'(r.col));
                    chk("best_rotation", 200'(best_rotation), 200'(r.rot));
                    chk("best_cleared", 200'(best_cleared), 200'(r.cleared));
                    chk("best_board", best_board, r.board);
                    chk("done_latency", 200'(cyc - start_cyc), 200'(r.lat));
                    chk("busy_at_done", 200'(busy), 200'(0));
                end
            end
        end
    end

    function automatic int n_rot(input int b);
        if (b == 1) return 1;
        if (b == 2 || b == 5 || b == 6) return 4;
        return 2;
    endfunction

    task automatic push_reqs(input int b, input logic [199:0] brd, input int count);
        int n;
        n = 0;
        for (int r = 0; r < n_rot(b); r++)
            for (int c = 0; c < 10; c++) begin
                if (n < count) exp_req.push_back('{4'(b), 4'(c), 2'(r), brd});
                n++;
            end
    endtask

    task automatic launch(input int b, input logic [199:0] brd);
        @(negedge clk);
        cur_block = 4'(b);
        cur_board = brd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_res.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_res.size() > 0) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=no_done required=done");
            exp_res.delete();
            exp_req.delete();
        end
    endtask

    task automatic run_search(input int m, input int b, input logic [199:0] brd,
                              input res_t r);
        mode = m;
        push_reqs(b, brd, 1000);
        exp_res.push_back(r);
        launch(b, brd);
        wait_done(400);
    endtask

    initial begin
        logic [199:0] brd;
        int n;
        brd = {50{4'hA}};
        rst = 1'b1; start = 1'b0; cur_block = '0; cur_board = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 200'(busy), 200'(0));
        chk("rst_done", 200'(done), 200'(0));
        chk("rst_found", 200'(found), 200'(0));
        chk("rst_best_col", 200'(best_col), 200'(0));
        chk("rst_best_board", best_board, '0);
        chk("rst_sim_request", 200'(sim_bus.sim_request), 200'(0));
        chk("rst_sim_board", sim_bus.sim_board, '0);
        rst = 1'b0;

        run_search(1, 1, brd, '{1'b1, 4'd0, 2'd0, 10'd0, tag_board(0, 0), 31});
        run_search(2, 2, brd ^ 200'h5, '{1'b1, 4'd5, 2'd2, 10'd1, tag_board(5, 2), 121});
        run_search(3, 3, brd, '{1'b0, 4'd0, 2'd0, 10'd0, '0, 61});
        run_search(4, 1, brd, '{1'b1, 4'd7, 2'd0, 10'd1, tag_board(7, 0), 34});
        repeat (3) @(negedge clk);
        chk("hold_found", 200'(found), 200'(1));
        chk("hold_best_col", 200'(best_col), 200'(7));
        chk("hold_best_board", best_board, tag_board(7, 0));
        run_search(7, 4, brd, '{1'b1, 4'd9, 2'd1, 10'd0, '0, 61});

        // Reset in the WAIT of candidate 1 (withheld), then a stray sim_ready.
        mode = 5;
        push_reqs(1, brd, 2);
        launch(1, brd);
        n = 0;
        while (!(sim_bus.sim_request && sim_bus.sim_col == 4'd1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 200'(busy), 200'(0));
        chk("midrst_sim_request", 200'(sim_bus.sim_request), 200'(0));
        chk("midrst_found", 200'(found), 200'(0));
        chk("midrst_reqs_left", 200'(exp_req.size()), 200'(0));
        late_pulse = 1'b1;
        repeat (5) @(negedge clk);
        chk("late_ready_busy", 200'(busy), 200'(0));
        chk("late_ready_found", 200'(found), 200'(0));
        run_search(1, 1, brd, '{1'b1, 4'd0, 2'd0, 10'd0, tag_board(0, 0), 31});

        // Start pulses mid-search and in the DONE cycle must be ignored.
        mode = 1;
        push_reqs(1, brd, 1000);
        exp_res.push_back('{1'b1, 4'd0, 2'd0, 10'd0, tag_board(0, 0), 31});
        launch(1, brd);
        repeat (10) @(negedge clk);
        cur_block = 4'd2;
        cur_board = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cyc < start_cyc + 30 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        repeat (4) @(negedge clk);
        chk("done_start_ignored_busy", 200'(busy), 200'(0));
        chk("done_start_reqs_left", 200'(exp_req.size()), 200'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/board_placement_search.md
BOARD_PLACEMENT_SEARCH -- requirements
Module: board_placement_search

Interface
REQ-001 Parameter CLEAR_WEIGHT, default 8, score added per cleared line.
REQ-002 Parameter HEIGHT_WEIGHT, default 1, score subtracted per row of stack height.
REQ-003 Parameter SIM_TIMEOUT, default 4, maximum WAIT cycles for sim_ready.
REQ-004 The block SHALL use one clock, clk; reset is rst, synchronous, active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  request a search; sampled only in IDLE.
REQ-008 cur_block  in  4  piece id; snapshot at start.
REQ-009 cur_board  in  200  board, row r at [r*10 +: 10], row 0 top; snapshot at start.
REQ-010 sim_block, sim_col, sim_rotation, sim_board  out  4/4/2/200  candidate driven to the downstream board simulator.
REQ-011 sim_request  out  1  one-cycle request pulse to the simulator.
REQ-012 sim_valid, sim_next_board, sim_cleared_lines, sim_ready  in  1/200/10/1  simulator results; sim_ready is a one-cycle strobe.
REQ-013 busy  out  1  high from the cycle after start is accepted until done.
REQ-014 done  out  1  one-cycle pulse when the result is final.
REQ-015 found  out  1  at least one valid candidate exists.
REQ-016 best_col, best_rotation, best_cleared, best_board  out  4/2/10/200  winning candidate and its result.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, SCORE, DONE; all outputs registered.
REQ-018 IDLE with start=1 -> ISSUE: snapshot cur_block/cur_board, set rot=0, col=0, best score to "none", found=0.
REQ-019 ISSUE SHALL drive sim_request=1 for exactly one cycle with sim_* = snapshot block/board, current col/rot, then enter WAIT.
REQ-020 WAIT SHALL capture sim_valid, sim_next_board and sim_cleared_lines in the cycle sim_ready=1 and enter SCORE.
REQ-021 If sim_ready is not seen within SIM_TIMEOUT WAIT cycles, the candidate SHALL be treated as invalid and the FSM SHALL enter SCORE.
REQ-022 sim_ready outside WAIT SHALL be ignored.
REQ-023 height = 20 - index of topmost nonzero row of the captured board, or 0 if empty.
REQ-024 score = CLEAR_WEIGHT*cleared - HEIGHT_WEIGHT*height, 16-bit signed, computed in SCORE.
REQ-025 SCORE SHALL replace best_* and set found=1 only if the candidate is valid and (found=0 or score strictly greater than best score); ties keep the earlier candidate.
REQ-026 Candidate order: rotation outer, col inner; col 0..9; rotations 0 only for block 1, 0..3 for blocks 2,5,6, 0..1 for all other ids.
REQ-027 SCORE SHALL advance to the next candidate -> ISSUE, or after the last candidate -> DONE.
REQ-028 DONE SHALL assert done=1 for one cycle, drop busy, return to IDLE.
REQ-029 Without timeouts, with K candidates, done SHALL assert exactly 3K+1 cycles after the start edge: 31 cycles for K=10, 121 for K=40.
REQ-030 found=0 at done SHALL force best_col=0, best_rotation=0, best_cleared=0, best_board=0.
REQ-031 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-032 best_* and found SHALL hold their values after done until the next accepted start.

Reset
REQ-033 rst=1 SHALL force IDLE and zero every output, including sim_request, busy, done, found and best_*, on the next edge, from any state.
REQ-034 Reset mid-search SHALL abandon the search with no done pulse; a later sim_ready SHALL be ignored.

Verification
REQ-035 Stub sim returns valid=1, cleared=0, height 2 for all; block 1 -> 10 requests, cols 0..9 rot 0, done at cycle 31, found=1, best_col=0, best_rotation=0.
REQ-036 Block 2, stub returns cleared=1 only for rot 2 col 5 -> 40 requests, done at cycle 121, best_rotation=2, best_col=5, best_cleared=1.
REQ-037 Stub returns valid=0 for all -> found=0, best_col=0, best_rotation=0, best_cleared=0, best_board=0.
REQ-038 Stub withholds sim_ready for candidate 3 of block 1 -> candidate skipped after 4 WAIT cycles, done at cycle 34.
REQ-039 rst pulsed during WAIT -> busy=0 and sim_request=0 next cycle, no done, late sim_ready ignored; a new start completes normally.
REQ-040 start pulsed again mid-search -> no restart, request count unchanged, single done pulse.
